// File: rtl/mips_muldiv_32.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply (LSB first) and restoring divide (MSB first), 32 steps each.
module mips_muldiv_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t      state, state_nxt;
    logic [4:0]  step_cnt;

    // Operation context captured at issue
    logic        is_div, neg_q, neg_r, b_zero;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic [31:0] dvd, dsr, quot, rem;

    logic        issue, signed_op;
    logic [31:0] a_mag, b_mag;
    logic [32:0] trial, diff;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cneg64(input logic [63:0] v, input logic n);
        return n ? (~v + 64'd1) : v;
    endfunction

    assign busy      = (state != IDLE);
    assign issue     = (state == IDLE) && start && !op[2];
    assign signed_op = !op[0];
    assign a_mag     = cneg32(a, signed_op & a[31]);
    assign b_mag     = cneg32(b, signed_op & b[31]);

    // Restoring step: bit 32 of the difference is the borrow, i.e. trial < divisor
    assign trial     = {rem, dvd[31]};
    assign diff      = trial - {1'b0, dsr};

    assign prod_fix  = cneg64(acc, neg_q);
    assign quot_fix  = b_zero ? 32'hFFFF_FFFF : cneg32(quot, neg_q);
    assign rem_fix   = cneg32(rem, neg_r);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = RUN;
            RUN:     if (step_cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            step_cnt <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_nxt;
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    step_cnt <= '0;
                    if (start && op == OP_MTHI) hi <= a;
                    if (start && op == OP_MTLO) lo <= a;
                end
                RUN: step_cnt <= step_cnt + 5'd1;
                FIX: begin
                    done     <= 1'b1;
                    div_zero <= is_div & b_zero;
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: step_cnt <= '0;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always loaded at issue
    always_ff @(posedge clk) begin
        if (issue) begin
            is_div <= op[1];
            neg_q  <= signed_op & (a[31] ^ b[31]);
            neg_r  <= signed_op & a[31];
            b_zero <= (b == 32'd0);
            mcand  <= {32'd0, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            dvd    <= a_mag;
            dsr    <= b_mag;
            rem    <= '0;
            quot   <= '0;
        end else if (state == RUN) begin
            if (!is_div) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end else begin
                dvd <= dvd << 1;
                if (!diff[32]) begin
                    rem  <= diff[31:0];
                    quot <= {quot[30:0], 1'b1};
                end else begin
                    rem  <= trial[31:0];
                    quot <= {quot[30:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_muldiv_32.sv
// Scoreboard bench for mips_muldiv_32: directed test-plan cases, random ops
// against a behavioural model, MTHI/MTLO, busy hazards and mid-operation reset.
module tb_mips_muldiv_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mips_muldiv_32 dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        logic signed [31:0] qs, rs;
        case (o)
            3'd0: begin
                ps = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return {1'b0, ps};
            end
            3'd1: begin
                pu = {32'd0, x} * {32'd0, y};
                return {1'b0, pu};
            end
            3'd2: begin
                if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
                qs = $signed(x) / $signed(y);
                rs = $signed(x) % $signed(y);
                return {1'b0, rs, qs};
            end
            3'd3: begin
                if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
            default: return 65'd0;
        endcase
    endfunction

    // Output monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0) begin
            check("busy_done_excl", {63'd0, busy & done}, 64'd0);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("hi", {32'd0, hi}, {32'd0, e.hi});
                    check("lo", {32'd0, lo}, {32'd0, e.lo});
                    check("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
                end
            end
        end
    end

    // Issue one mult/div and follow it to done; now=1 issues in the current
    // (done) cycle, hz=1 fires ignored MULTU and MTHI starts while busy.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input bit now, input bit hz);
        exp_t e;
        int   cyc, busy_cnt;
        if (!now) @(negedge clk);
        e.hi = ehi; e.lo = elo; e.dz = edz;
        sb.push_back(e);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; busy_cnt = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cnt++;
            if (hz && cyc == 5) begin
                start = 1'b1; op = 3'b001; a = 32'd2; b = 32'd3;
            end else if (hz && cyc == 6) begin
                op = 3'b100; a = 32'hDEAD_BEEF;
            end else if (hz && cyc == 7) begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("busy_cycles", busy_cnt, 33);
        check("done_latency", cyc, 33);
    endtask

    initial begin
        logic [64:0] r;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_ctrl", {61'd0, busy, done, div_zero}, 64'd0);
        reset = 1'b0;

        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        do_op(3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1, 1'b0);
        do_op(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0, 1'b1, 1'b0);
        do_op(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0);
        do_op(3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        do_op(3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        do_op(3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        do_op(3'b010, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : $urandom >> $urandom_range(0, 28);
            r  = model(ro, ra, rb);
            do_op(ro, ra, rb, r[63:32], r[31:0], r[64], 1'b0, 1'b0);
        end

        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'h1234_5678;
        @(negedge clk);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        check("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        op = 3'b101; a = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_busy", {63'd0, busy}, 64'd0);
        check("mtlo_hi", {32'd0, hi}, 64'h1234_5678);
        check("mtlo_lo", {32'd0, lo}, 64'h9ABC_DEF0);
        op = 3'b110; start = 1'b1; a = 32'h5555_5555;
        @(negedge clk);
        start = 1'b0;
        check("noop_hi", {32'd0, hi}, 64'h1234_5678);
        check("noop_lo", {32'd0, lo}, 64'h9ABC_DEF0);
        check("noop_busy", {63'd0, busy}, 64'd0);

        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("hazard_hi_kept", {32'd0, hi}, 64'hFFFF_FFFE);
        check("hazard_lo_kept", {32'd0, lo}, 64'h0000_0001);

        @(negedge clk);
        start = 1'b1; op = 3'b001; a = 32'hFFFF_FFFF; b = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        check("abort_ctrl", {61'd0, busy, done, div_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("post_abort_busy", {63'd0, busy}, 64'd0);
        do_op(3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
